// File: rtl/vec_gather.sv
// Double-banked element gatherer: packs a/b element pairs into vectors
// for the dot-product stage, with zero padding of short vectors.
module vec_gather #(
  parameter int VSIZE = 4,
  parameter int LW    = $clog2(VSIZE+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         s_a,
  input  logic [31:0]         s_b,
  input  logic                s_last,
  output logic [32*VSIZE-1:0] vec_a,
  output logic [32*VSIZE-1:0] vec_b,
  output logic [LW-1:0]       vec_len,
  output logic                vec_valid,
  input  logic                vec_ready
);

  localparam int IW = $clog2(VSIZE);

  logic [31:0]   mem_a [2][VSIZE];
  logic [31:0]   mem_b [2][VSIZE];
  logic [LW-1:0] len_q [2];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] idx;

  logic in_xfer;
  logic out_xfer;
  logic closing;

  assign s_ready   = !full[wr_bank];
  assign in_xfer   = s_valid && s_ready;
  assign closing   = s_last || (idx == IW'(VSIZE-1));
  assign vec_valid = full[rd_bank];
  assign out_xfer  = vec_valid && vec_ready;
  assign vec_len   = len_q[rd_bank];

  // Present the read bank's slots as flat vectors.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    for (int k = 0; k < VSIZE; k++) begin
      vec_a[32*k +: 32] = mem_a[rd_bank][k];
      vec_b[32*k +: 32] = mem_b[rd_bank][k];
    end
  end

  // Bank storage: fill the write bank, scrub the read bank on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        len_q[b] <= '0;
        for (int k = 0; k < VSIZE; k++) begin
          mem_a[b][k] <= '0;
          mem_b[b][k] <= '0;
        end
      end
    end else begin
      if (out_xfer) begin
        len_q[rd_bank] <= '0;
        for (int k = 0; k < VSIZE; k++) begin
          mem_a[rd_bank][k] <= '0;
          mem_b[rd_bank][k] <= '0;
        end
      end
      if (in_xfer) begin
        mem_a[wr_bank][idx] <= s_a;
        mem_b[wr_bank][idx] <= s_b;
        if (closing)
          len_q[wr_bank] <= LW'(idx) + LW'(1);
      end
    end
  end

  // Bank pointers, slot index and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx     <= '0;
    end else begin
      if (out_xfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
      if (in_xfer) begin
        if (closing) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          idx           <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_gather.sv
// Bench for vec_gather: directed scenarios plus random traffic,
// checked against a queue-of-vectors reference model.
module tb_vec_gather;

  localparam int VS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_a = '0;
  logic [31:0]  s_b = '0;
  logic         s_last = 1'b0;
  logic [127:0] vec_a;
  logic [127:0] vec_b;
  logic [2:0]   vec_len;
  logic         vec_valid;
  logic         vec_ready = 1'b0;

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic [2:0]   len;
  } vec_t;

  vec_t         fq[$];
  logic [127:0] cur_a;
  logic [127:0] cur_b;
  int           cnt;
  int           checks;
  int           errors;
  int           acc;

  vec_gather #(.VSIZE(VS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .vec_a(vec_a), .vec_b(vec_b),
    .vec_len(vec_len), .vec_valid(vec_valid),
    .vec_ready(vec_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    cur_a = '0;
    cur_b = '0;
    cnt   = 0;
  endtask

  // Full output comparison against the model's view of the banks.
  task automatic check_outs(input string tag);
    chk({tag, ".s_ready"}, 128'(s_ready), 128'(fq.size() < 2));
    chk({tag, ".valid"}, 128'(vec_valid), 128'(fq.size() > 0));
    if (fq.size() > 0) begin
      chk({tag, ".vec_a"}, vec_a, fq[0].a);
      chk({tag, ".vec_b"}, vec_b, fq[0].b);
      chk({tag, ".len"}, 128'(vec_len), 128'(fq[0].len));
    end else begin
      chk({tag, ".vec_a"}, vec_a, cur_a);
      chk({tag, ".vec_b"}, vec_b, cur_b);
      chk({tag, ".len"}, 128'(vec_len), 128'(0));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic l,
                      input logic r);
    logic xin;
    logic xout;
    vec_t t;
    check_outs("step");
    s_valid   = v;
    s_a       = a;
    s_b       = b;
    s_last    = l;
    vec_ready = r;
    xin  = v && (fq.size() < 2);
    xout = r && (fq.size() > 0);
    if (v && s_ready) acc++;
    @(posedge clk);
    #1;
    if (xout) t = fq.pop_front();
    if (xin) begin
      cur_a[32*cnt +: 32] = a;
      cur_b[32*cnt +: 32] = b;
      cnt++;
      if (l || cnt == VS) begin
        t.a   = cur_a;
        t.b   = cur_b;
        t.len = 3'(cnt);
        fq.push_back(t);
        cur_a = '0;
        cur_b = '0;
        cnt   = 0;
      end
    end
    s_valid = 1'b0;
  endtask

  logic [31:0]  e [12];
  logic [127:0] hold_a;
  logic [127:0] hold_b;
  logic [16:0]  vmask;

  initial begin
    checks = 0;
    errors = 0;
    acc    = 0;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    check_outs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full 4-element vector, consumer always ready.
    step(1, 32'h3F800000, 32'h11, 0, 1);
    step(1, 32'h40000000, 32'h22, 0, 1);
    step(1, 32'h40400000, 32'h33, 0, 1);
    step(1, 32'h40800000, 32'h44, 1, 1);
    chk("r33.valid", 128'(vec_valid), 128'(1));
    chk("r33.len", 128'(vec_len), 128'(4));
    chk("r33.vec_a", vec_a,
        {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    step(0, 0, 0, 0, 1);
    chk("r33.drop", 128'(vec_valid), 128'(0));

    // Short vector: zero padding above the last element.
    step(1, 32'hAAAA0001, 32'hBBBB0001, 0, 0);
    step(1, 32'hAAAA0002, 32'hBBBB0002, 1, 0);
    chk("r34.len", 128'(vec_len), 128'(2));
    chk("r34.pad_a", 128'(vec_a[127:64]), 128'(0));
    chk("r34.pad_b", 128'(vec_b[127:64]), 128'(0));
    step(0, 0, 0, 0, 1);

    // Backpressure: only two banks' worth accepted.
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      e[i] = $urandom;
      step(1, e[i], ~e[i], 0, 0);
    end
    chk("r35.acc", 128'(acc), 128'(8));
    chk("r35.stall", 128'(s_ready), 128'(0));
    chk("r35.first", vec_a, {e[3], e[2], e[1], e[0]});
    hold_a = vec_a;
    hold_b = vec_b;
    for (int i = 0; i < 5; i++) begin
      step(0, $urandom, $urandom, 1, 0);
      chk("r38.a", vec_a, hold_a);
      chk("r38.b", vec_b, hold_b);
      chk("r38.len", 128'(vec_len), 128'(4));
    end
    step(0, 0, 0, 0, 1);
    chk("r35.resume", 128'(s_ready), 128'(1));
    chk("r35.second", vec_a, {e[7], e[6], e[5], e[4]});
    step(0, 0, 0, 0, 1);

    // Streaming: one element per cycle, vectors spaced 4 apart.
    for (int i = 0; i < 17; i++) begin
      vmask[i] = vec_valid;
      step(i < 16, $urandom, $urandom, 0, 1);
    end
    chk("r36.mask", 128'(vmask), 128'(17'h11110));

    // Mid-stream asynchronous reset.
    step(1, 32'hDEAD0001, 32'hBEEF0001, 0, 0);
    step(1, 32'hDEAD0002, 32'hBEEF0002, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("r37.async");
    chk("r37.a0", vec_a, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      e[i] = $urandom;
      step(1, e[i], e[i] ^ 32'h5A5A5A5A, i == 3, 0);
    end
    chk("r37.len", 128'(vec_len), 128'(4));
    chk("r37.vec_a", vec_a, {e[3], e[2], e[1], e[0]});
    step(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    check_outs("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
